// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU/DMA side, the RAM macro and the RAM arbiter.
// The arbiter connects through the slave modport; the environment connects through master.
interface ram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              cpu_phi2;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              cpu_ram_cs;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rdy;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  cpu_phi2, cpu_addr, cpu_wdata, cpu_we, cpu_ram_cs,
        input  dma_req, dma_we, dma_addr, dma_wdata, ram_q,
        output cpu_rdata, cpu_rdy, dma_gnt, dma_rvalid, dma_rdata,
        output ram_addr, ram_wdata, ram_wren
    );

    modport master (
        output cpu_phi2, cpu_addr, cpu_wdata, cpu_we, cpu_ram_cs,
        output dma_req, dma_we, dma_addr, dma_wdata, ram_q,
        input  cpu_rdata, cpu_rdy, dma_gnt, dma_rvalid, dma_rdata,
        input  ram_addr, ram_wdata, ram_wren
    );
endinterface

// File: rtl/ram_arbiter.sv
// Slot-based arbiter sharing the single-port main RAM between the 65C02 and a DMA port.
// Each cpu_phi2 period is one slot owned by either the CPU or DMA; DMA slots stall the CPU via RDY.
module ram_arbiter #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 8,
    parameter int MAX_DMA_RUN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {CPU_A, CPU_B, DMA_A, DMA_B} state_e;

    localparam logic [3:0] MaxRun = 4'(MAX_DMA_RUN);

    state_e            state_q, state_d;
    logic [3:0]        run_cnt_q, run_cnt_d;
    logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
    logic [DATA_W-1:0] dma_wdata_q, dma_wdata_d;
    logic              dma_we_q, dma_we_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic in_dma;
    logic decide;
    logic go_dma;

    assign in_dma = (state_q == DMA_A) || (state_q == DMA_B);
    // An A state that sees cpu_phi2 high has lost phase and resyncs by deciding at once.
    assign decide = (state_q == CPU_B) || (state_q == DMA_B) || bus.cpu_phi2;
    assign go_dma = bus.dma_req && ((run_cnt_q < MaxRun) || !bus.cpu_ram_cs);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        dma_addr_d  = dma_addr_q;
        dma_wdata_d = dma_wdata_q;
        dma_we_d    = dma_we_q;
        rvalid_d    = (state_q == DMA_B) && !dma_we_q;
        rdata_d     = rdata_q;

        if (state_q == DMA_B && !dma_we_q) begin
            rdata_d = bus.ram_q;
        end

        if (decide) begin
            if (go_dma) begin
                state_d     = DMA_A;
                dma_addr_d  = bus.dma_addr;
                dma_wdata_d = bus.dma_wdata;
                dma_we_d    = bus.dma_we;
                if (bus.cpu_ram_cs && run_cnt_q != 4'hF) begin
                    run_cnt_d = run_cnt_q + 4'd1;
                end
            end else begin
                state_d   = CPU_A;
                run_cnt_d = '0;
            end
        end else if (state_q == CPU_A) begin
            state_d = CPU_B;
        end else if (state_q == DMA_A) begin
            state_d = DMA_B;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CPU_A;
            run_cnt_q   <= '0;
            dma_addr_q  <= '0;
            dma_wdata_q <= '0;
            dma_we_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            dma_addr_q  <= dma_addr_d;
            dma_wdata_q <= dma_wdata_d;
            dma_we_q    <= dma_we_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    // CPU slots pass the CPU bus straight through; DMA slots drive the latched request.
    always_comb begin
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
        bus.ram_wren  = bus.cpu_we & bus.cpu_ram_cs;
        bus.cpu_rdy   = 1'b1;
        if (in_dma) begin
            bus.cpu_rdy   = 1'b0;
            bus.ram_addr  = dma_addr_q;
            bus.ram_wdata = dma_wdata_q;
            bus.ram_wren  = (state_q == DMA_A) & dma_we_q;
        end
    end

    assign bus.cpu_rdata  = bus.ram_q;
    assign bus.dma_gnt    = (state_q == DMA_A);
    assign bus.dma_rvalid = rvalid_q;
    assign bus.dma_rdata  = rdata_q;
endmodule
